// File: rtl/song_play_sequencer.sv
// -----------------------------------------------------------------------------
// song_play_sequencer
//
// Chooses the note/octave request sent to the buzzer each cycle. When idle,
// the live keyboard request passes straight through. On a play request the
// block walks an external synchronous song ROM. For each entry it fetches the
// word, sounds the note for (beats * TICKS_PER_BEAT - GAP_TICKS) cycles, and
// then stays silent for GAP_TICKS cycles. Pressing a live key during a song
// overrides the outputs and pauses the song timing.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   play_btn        start request (level; rising edge detected here)
//   stop_btn        abort request (level)
//   live_note       keyboard note, 0 = none, 1..7 = do..ti
//   live_oct_up     live octave-up request
//   live_oct_down   live octave-down request
//   rom_addr        song ROM address
//   rom_data        ROM word, valid the cycle after rom_addr changes:
//                   [7:4] note (0 rest, 1..7 note, 15 end, 8..14 rest)
//                   [3:2] octave (01 up, 10 down, else normal)
//                   [1:0] beats-1
//   note_out        note to buzzer
//   octave_up_out   octave-up to buzzer
//   octave_down_out octave-down to buzzer
//   busy            song in progress
//   song_done       one-cycle pulse when the song ends naturally
// -----------------------------------------------------------------------------
module song_play_sequencer #(
  parameter int TICKS_PER_BEAT = 25000000,
  parameter int GAP_TICKS      = 2500000,
  parameter int ADDR_W         = 6,
  parameter int SONG_LEN       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play_btn,
  input  logic              stop_btn,
  input  logic [3:0]        live_note,
  input  logic              live_oct_up,
  input  logic              live_oct_down,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        note_out,
  output logic              octave_up_out,
  output logic              octave_down_out,
  output logic              busy,
  output logic              song_done
);

  localparam int TICK_W = $clog2(TICKS_PER_BEAT + 1);
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SOUND,
    GAP,
    DONE
  } state_t;

  state_t              state, state_next;
  logic                play_d;
  logic [ADDR_W-1:0]   addr_next;
  logic [1:0]          beat_cnt, beat_next, beat_dec;
  logic [TICK_W-1:0]   tick_cnt, tick_next, tick_dec;
  logic [3:0]          song_note, song_note_next;
  logic [1:0]          song_oct, song_oct_next;

  logic                play_rise;
  logic                live_active;
  logic                freeze;
  logic                busy_next;
  logic [3:0]          note_next;
  logic                up_next, down_next;

  assign play_rise   = play_btn & ~play_d;
  assign live_active = (live_note != 4'd0);
  // A held live key pauses the song by stopping the duration counters.
  assign freeze      = live_active && ((state == SOUND) || (state == GAP));

  // The beat and tick counters together count down the remaining cycles of
  // the current entry: remaining = beat_cnt * TICKS_PER_BEAT + tick_cnt + 1.
  always_comb begin
    if (tick_cnt == '0) begin
      tick_dec = TICK_MAX;
      beat_dec = beat_cnt - 2'd1;
    end else begin
      tick_dec = tick_cnt - 1'b1;
      beat_dec = beat_cnt;
    end
  end

  // Next-state and sequencing logic.
  always_comb begin
    state_next     = state;
    addr_next      = rom_addr;
    beat_next      = beat_cnt;
    tick_next      = tick_cnt;
    song_note_next = song_note;
    song_oct_next  = song_oct;

    if (stop_btn) begin
      state_next = IDLE;
      addr_next  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (play_rise) begin
            addr_next  = '0;
            state_next = FETCH;
          end
        end
        FETCH: state_next = LOAD;
        LOAD: begin
          song_note_next = rom_data[7:4];
          song_oct_next  = rom_data[3:2];
          if (rom_data[7:4] == 4'hF) begin
            state_next = DONE;
          end else begin
            beat_next  = rom_data[1:0];
            tick_next  = TICK_MAX;
            state_next = SOUND;
          end
        end
        SOUND: begin
          if (!freeze) begin
            beat_next = beat_dec;
            tick_next = tick_dec;
            // Exactly GAP_TICKS cycles remain after this one.
            if ((beat_cnt == 2'd0) && (tick_cnt == GAP_LAST)) begin
              state_next = GAP;
            end
          end
        end
        GAP: begin
          if (!freeze) begin
            beat_next = beat_dec;
            tick_next = tick_dec;
            if ((beat_cnt == 2'd0) && (tick_cnt == '0)) begin
              if (rom_addr == LAST_ADDR) begin
                state_next = DONE;
              end else begin
                addr_next  = rom_addr + 1'b1;
                state_next = FETCH;
              end
            end
          end
        end
        DONE: begin
          addr_next  = '0;
          state_next = IDLE;
        end
        default: begin
          addr_next  = '0;
          state_next = IDLE;
        end
      endcase
    end
  end

  // Outputs are computed for the state being entered. This keeps the
  // registered outputs aligned with the state register. They still react
  // to the inputs one cycle later.
  always_comb begin
    busy_next = (state_next == FETCH) || (state_next == LOAD) ||
                (state_next == SOUND) || (state_next == GAP);
    note_next = 4'd0;
    up_next   = 1'b0;
    down_next = 1'b0;
    if ((state_next == IDLE) || (busy_next && live_active)) begin
      note_next = live_note;
      up_next   = live_oct_up & ~live_oct_down;
      down_next = live_oct_down & ~live_oct_up;
    end else if (state_next == SOUND) begin
      // Codes 8..14 are rests; 15 never reaches SOUND.
      note_next = song_note_next[3] ? 4'd0 : song_note_next;
      up_next   = (song_oct_next == 2'b01);
      down_next = (song_oct_next == 2'b10);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      play_d          <= 1'b0;
      rom_addr        <= '0;
      beat_cnt        <= '0;
      tick_cnt        <= '0;
      song_note       <= '0;
      song_oct        <= '0;
      note_out        <= '0;
      octave_up_out   <= 1'b0;
      octave_down_out <= 1'b0;
      busy            <= 1'b0;
      song_done       <= 1'b0;
    end else begin
      state           <= state_next;
      play_d          <= play_btn;
      rom_addr        <= addr_next;
      beat_cnt        <= beat_next;
      tick_cnt        <= tick_next;
      song_note       <= song_note_next;
      song_oct        <= song_oct_next;
      note_out        <= note_next;
      octave_up_out   <= up_next;
      octave_down_out <= down_next;
      busy            <= busy_next;
      song_done       <= (state_next == DONE);
    end
  end

endmodule
